// File: rtl/sopc_run_monitor.sv
// Run observer beside mips_sopc: counts retirements, folds register writes into a
// rotating signature, and latches a sticky done on PC halt or cycle timeout.
module sopc_run_monitor #(
  parameter int HALT_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mon_en,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] if_pc,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt,
  output logic [31:0] signature,
  output logic [4:0]  last_waddr,
  output logic [31:0] last_wdata,
  output logic        halted,
  output logic        timeout,
  output logic        done
);

  localparam int CW = $clog2(HALT_CYCLES + 1);
  localparam logic [CW-1:0] HALT_MAX     = CW'(HALT_CYCLES);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED, ST_TIMEOUT} state_t;

  state_t        state;
  logic [31:0]   win_base;
  logic [CW-1:0] win_cnt;

  logic          in_win;
  logic          accept;
  logic [CW-1:0] win_cnt_nxt;
  logic [31:0]   cycle_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= HALT_MAX) ? HALT_MAX : v + 1'b1;
  endfunction

  function automatic logic [31:0] sig_fold(input logic [31:0] sig,
                                           input logic [31:0] data,
                                           input logic [4:0]  addr);
    return {sig[30:0], sig[31]} ^ data ^ {27'b0, addr};
  endfunction

  always_comb begin
    in_win      = (if_pc == win_base) || (if_pc == win_base + 32'd4);
    win_cnt_nxt = in_win ? sat_inc(win_cnt) : CW'(1);
    accept      = wb_we && (wb_waddr != 5'd0);
    cycle_nxt   = cycle_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      signature  <= '0;
      last_waddr <= '0;
      last_wdata <= '0;
      win_base   <= '0;
      win_cnt    <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mon_en) begin
            state    <= ST_RUN;
            win_base <= if_pc;
            win_cnt  <= CW'(1);
          end
        end
        ST_RUN: begin
          // The edge that leaves RUN still records its cycle and write.
          cycle_cnt <= cycle_nxt;
          if (accept) begin
            retire_cnt <= retire_cnt + 32'd1;
            signature  <= sig_fold(signature, wb_wdata, wb_waddr);
            last_waddr <= wb_waddr;
            last_wdata <= wb_wdata;
          end
          win_cnt <= win_cnt_nxt;
          if (!in_win) win_base <= if_pc;
          if (!mon_en) begin
            state <= ST_IDLE;
          end else if (win_cnt_nxt == HALT_MAX) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
            done   <= 1'b1;
          end else if (cycle_nxt == TIMEOUT_LAST) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
